// File: rtl/booth_xactor_pkg.sv
// Shared types and default parameters for the booth multiplier stream transactor.
// Optional watchdog is enabled by defining BOOTH_XACTOR_WATCHDOG_EN.
package booth_xactor_pkg;

    localparam int unsigned XACT_DATA_WIDTH     = 32;
    localparam int unsigned XACT_IN_DEPTH       = 4;
    localparam int unsigned XACT_OUT_DEPTH      = 4;
    localparam int unsigned XACT_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_BUSY       = 2'd3
    } xact_state_t;

    // Output entry at the default width; the top builds the same layout for its own DATA_WIDTH
    typedef struct packed {
        logic [2*XACT_DATA_WIDTH-1:0] product;
        logic                         eom;
        logic                         err;
    } xact_entry_t;

endpackage

// File: rtl/booth_xactor_fifo.sv
// Synchronous count-based FIFO with registered full/empty flags and a reset storage array.
module booth_xactor_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_push_c = push & ~full;
    assign do_pop_c  = pop & ~empty;
    assign rd_data   = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        case ({do_push_c, do_pop_c})
            2'b10:   count_next_c = count + CW'(1);
            2'b01:   count_next_c = count - CW'(1);
            default: count_next_c = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
            count <= count_next_c;
            full  <= (count_next_c == CW'(DEPTH));
            empty <= (count_next_c == '0);
        end
    end

endmodule

// File: rtl/booth_stream_xactor.sv
// Operand/result transactor between valid/ready streams and a booth_fsm multiplier.
// Define BOOTH_XACTOR_WATCHDOG_EN to abort stalled operations after TIMEOUT_CYCLES.
module booth_stream_xactor
    import booth_xactor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = XACT_DATA_WIDTH,
    parameter int unsigned IN_DEPTH       = XACT_IN_DEPTH,
    parameter int unsigned OUT_DEPTH      = XACT_OUT_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = XACT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_operands,
    input  logic                    in_eom,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_product,
    output logic                    out_eom,
    output logic                    out_err,
    output logic                    load,
    output logic [DATA_WIDTH-1:0]   m,
    output logic [DATA_WIDTH-1:0]   r,
    input  logic [2*DATA_WIDTH-1:0] product,
    input  logic                    done,
    output logic                    busy,
    output logic                    err_sticky
);
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned IW = PW + 1;

    typedef struct packed {
        logic [PW-1:0] product;
        logic          eom;
        logic          err;
    } out_entry_t;

    localparam int unsigned OW = $bits(out_entry_t);

    if (DATA_WIDTH == 0) begin : g_bad_width
        $error("DATA_WIDTH must be non-zero");
    end
    if (IN_DEPTH < 2 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : g_bad_in_depth
        $error("IN_DEPTH must be a power of two >= 2");
    end
    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_out_depth
        $error("OUT_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    xact_state_t state;
    xact_state_t state_next;
    logic [IW-1:0] in_head;
    logic          in_full;
    logic          in_empty;
    logic          in_pop_c;
    out_entry_t    out_head;
    out_entry_t    out_wdata_c;
    logic          out_full;
    logic          out_empty;
    logic          out_push_c;
    logic          saved_eom;
    logic          wd_hit_c;

    booth_xactor_fifo #(.WIDTH(IW), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .pop     (in_pop_c),
        .wr_data ({in_eom, in_operands}),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty)
    );

    booth_xactor_fifo #(.WIDTH(OW), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (out_push_c),
        .pop     (out_ready),
        .wr_data (out_wdata_c),
        .rd_data (out_head),
        .full    (out_full),
        .empty   (out_empty)
    );

    assign in_ready    = ~in_full;
    assign out_valid   = ~out_empty;
    assign out_product = out_head.product;
    assign out_eom     = out_head.eom;
    assign out_err     = out_head.err;

    // Issue only when the output FIFO can take the single in-flight result
    always_comb begin
        state_next  = state;
        in_pop_c    = 1'b0;
        out_push_c  = 1'b0;
        out_wdata_c = '{product: product, eom: saved_eom, err: 1'b0};
        case (state)
            ST_IDLE: begin
                if (!in_empty && done && !out_full) begin
                    in_pop_c   = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: state_next = ST_WAIT_START;
            ST_WAIT_START: begin
                if (!done) begin
                    state_next = ST_BUSY;
                end else if (wd_hit_c) begin
                    out_push_c  = 1'b1;
                    out_wdata_c = '{product: '1, eom: saved_eom, err: 1'b1};
                    state_next  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    out_push_c = 1'b1;
                    state_next = ST_IDLE;
                end else if (wd_hit_c) begin
                    out_push_c  = 1'b1;
                    out_wdata_c = '{product: '1, eom: saved_eom, err: 1'b1};
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            load      <= 1'b0;
            m         <= '0;
            r         <= '0;
            saved_eom <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            load  <= (state_next == ST_LOAD);
            if (in_pop_c) begin
                saved_eom <= in_head[PW];
                m         <= in_head[PW-1:DATA_WIDTH];
                r         <= in_head[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef BOOTH_XACTOR_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign wd_hit_c   = (wd_cnt == WD_W'(TIMEOUT_CYCLES));
    assign err_sticky = err_q;

    // Restart on every entry into a waiting state, count while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_next != state &&
                (state_next == ST_WAIT_START || state_next == ST_BUSY)) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT_START || state == ST_BUSY) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (out_push_c && out_wdata_c.err) err_q <= 1'b1;
        end
    end
`else
    assign wd_hit_c   = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_booth_stream_xactor.sv
// Randomized scoreboard bench for booth_stream_xactor with a behavioural multiplier stub.
module tb_booth_stream_xactor;
    import booth_xactor_pkg::*;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2*W-1:0] in_operands;
    logic          in_eom;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic          out_eom;
    logic          out_err;
    logic          load;
    logic [W-1:0]  m;
    logic [W-1:0]  r;
    logic [2*W-1:0] product;
    logic          done;
    logic          busy;
    logic          err_sticky;

    int            checks = 0;
    int            errors = 0;
    int            load_cnt = 0;
    logic          prev_load = 1'b0;
    logic          hold_ready = 1'b1;
    logic          stub_hang = 1'b0;
    int            stub_lat;
    logic [2*W-1:0] stub_prod;
    xact_entry_t   sb[$];

    booth_stream_xactor #(
        .DATA_WIDTH(W), .IN_DEPTH(4), .OUT_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_operands(in_operands), .in_eom(in_eom), .out_valid(out_valid),
        .out_ready(out_ready), .out_product(out_product), .out_eom(out_eom),
        .out_err(out_err), .load(load), .m(m), .r(r), .product(product),
        .done(done), .busy(busy), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: two's-complement product of the two W-bit operands
    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb2;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        return 64'(sa * sb2);
    endfunction

    // Multiplier stub: drops done after load, raises it after a random latency
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b1;
            stub_lat <= 0;
            product  <= '0;
        end else if (load) begin
            done      <= 1'b0;
            stub_lat  <= int'($urandom_range(1, 6));
            product   <= 64'hDEAD_BEEF_DEAD_BEEF;
            stub_prod <= mul_ref(m, r);
        end else if (!done && !stub_hang) begin
            if (stub_lat == 0) begin
                done    <= 1'b1;
                product <= stub_prod;
            end else begin
                stub_lat <= stub_lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: load pulse shape and scoreboard comparison of every popped entry
    always @(negedge clk) begin
        if (!reset) begin
            if (load) begin
                load_cnt++;
                chk("load_single_cycle", 64'(prev_load), 64'd0);
            end
            prev_load = load;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", out_product);
                end else begin
                    xact_entry_t e;
                    e = sb.pop_front();
                    chk("out_product", out_product, e.product);
                    chk("out_eom", 64'(out_eom), 64'(e.eom));
                    chk("out_err", 64'(out_err), 64'(e.err));
                end
            end
        end else begin
            prev_load = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic eom,
                        input logic [63:0] exp, input logic err);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_operands = {a, b};
        in_eom      = eom;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{product: exp, eom: eom, err: err});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || out_valid || busy) && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_complete", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_load"}, 64'(load), 64'd0);
        chk({tag, "_m"}, 64'(m), 64'd0);
        chk({tag, "_r"}, 64'(r), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_eom"}, 64'(out_eom), 64'd0);
        chk({tag, "_out_err"}, 64'(out_err), 64'd0);
        chk({tag, "_out_product"}, out_product, 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        e;
        int          base;
        int          guard;

        reset       = 1'b0;
        in_valid    = 1'b0;
        in_operands = '0;
        in_eom      = 1'b0;
        #1 reset = 1'b1;
        #1 chk_reset_values("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_output", 64'(out_valid), 64'd0);
        chk("idle_not_busy", 64'(busy), 64'd0);

        // Directed products, including signed corner cases
        hold_ready = 1'b0;
        send(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        wait_drain(500);

        // Backpressure: output FIFO fills, issuing stops, input FIFO fills
        hold_ready = 1'b1;
        base = load_cnt;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            send(a, b, (i == 7), mul_ref(a, b), 1'b0);
        end
        repeat (60) @(negedge clk);
        chk("bp_issue_count", 64'(load_cnt - base), 64'd4);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_idle_waiting", 64'(busy), 64'd0);
        hold_ready = 1'b0;
        wait_drain(1000);

        // Random traffic with random sink backpressure
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            e = 1'($urandom_range(0, 1));
            if (i % 8 == 0) a = 32'h8000_0000;
            if (i % 8 == 1) b = 32'd0;
            send(a, b, e, mul_ref(a, b), 1'b0);
        end
        wait_drain(3000);

        // Reset while the multiplier is busy discards the in-flight operation
        stub_hang = 1'b1;
        send(32'd1234, 32'd5678, 1'b1, mul_ref(32'd1234, 32'd5678), 1'b0);
        guard = 0;
        while (!(busy && !done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_busy", 64'(busy && !done), 64'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_values("midop_reset");
        sb.delete();
        stub_hang = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_reset_no_stale", 64'(out_valid), 64'd0);
        send(32'd7, 32'd6, 1'b1, 64'd42, 1'b0);
        wait_drain(500);

        // Multiplier that never completes
        stub_hang = 1'b1;
        a = $urandom;
        b = $urandom;
`ifdef BOOTH_XACTOR_WATCHDOG_EN
        send(a, b, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_drain(300);
        chk("wd_err_sticky", 64'(err_sticky), 64'd1);
        stub_hang = 1'b0;
        repeat (20) @(negedge clk);
`else
        send(a, b, 1'b1, mul_ref(a, b), 1'b0);
        repeat (1000) @(negedge clk);
        chk("hang_busy", 64'(busy), 64'd1);
        chk("hang_no_output", 64'(out_valid), 64'd0);
        chk("hang_err_sticky", 64'(err_sticky), 64'd0);
        stub_hang = 1'b0;
        wait_drain(500);
`endif
        send(32'd9, 32'd11, 1'b1, 64'd99, 1'b0);
        wait_drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
